// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register write-port arbiter and its
// sibling read-port arbiter.
package reg_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 2;

  // Index width that stays at least one bit for single-entry vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ.
module rr_picker
  import reg_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IW-1:0]    winner_idx,
  output logic             valid
);

  logic [IW-1:0] cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        winner_idx  = cand;
        winner[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin owner of the register-bank write port with capped bursts,
// registered one-hot enables and a shared registered data bus.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no owner; pick next requester from ptr, grant on next edge
//   ST_OWN  | owner holds the port; its writes go out until release
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int N_REG     = 4,
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_last,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REG-1:0]    reg_en,
  output logic [DW-1:0]       reg_din,
  output logic                addr_err,
  output logic                busy
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = idx_w(MAX_BURST);

  arb_state_e       state, next_state;
  logic [IW-1:0]    ptr, own_idx, ptr_next;
  logic [CW-1:0]    cnt;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

  logic             own_req, own_last;
  logic [AW-1:0]    own_addr;
  logic [DW-1:0]    own_data;
  logic [N_REG-1:0] dec;
  logic             accept, rel, cnt_max;

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req        (req),
    .ptr        (ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // Owner's request fields, selected by the registered owner index.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_addr = '0;
    own_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (own_idx == IW'(i)) begin
        own_req  = req[i];
        own_last = req_last[i];
        own_addr = req_addr[i*AW +: AW];
        own_data = req_data[i*DW +: DW];
      end
    end
  end

  // Out-of-range addresses decode to all zeros, which also flags addr_err.
  always_comb begin
    dec = '0;
    for (int r = 0; r < N_REG; r++) begin
      dec[r] = (own_addr == AW'(r));
    end
  end

  assign busy     = (state == ST_OWN);
  assign ack      = busy ? (gnt & req) : '0;
  assign cnt_max  = (cnt == CW'(MAX_BURST - 1));
  assign ptr_next = (own_idx == IW'(N_REQ - 1)) ? '0 : own_idx + IW'(1);

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    rel        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) next_state = ST_OWN;
      end
      ST_OWN: begin
        accept = own_req;
        rel    = ~own_req | own_last | cnt_max;
        if (rel) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      own_idx  <= '0;
      ptr      <= '0;
      cnt      <= '0;
      reg_en   <= '0;
      reg_din  <= '0;
      addr_err <= 1'b0;
    end else begin
      state    <= next_state;
      reg_en   <= accept ? dec : '0;
      addr_err <= accept & ~|dec;
      if (accept) begin
        reg_din <= own_data;
        cnt     <= cnt + CW'(1);
      end
      if (state == ST_IDLE && pick_valid) begin
        gnt     <= pick_onehot;
        own_idx <= pick_idx;
        cnt     <= '0;
      end
      // Release wins over the increment so cnt never passes MAX_BURST-1.
      if (rel) begin
        gnt <= '0;
        cnt <= '0;
        ptr <= ptr_next;
      end
    end
  end

endmodule
